// File: rtl/mod_n_updown_counter.sv
// Modulo-N loadable up/down counter with programmable step, wrap/saturate
// boundary handling, terminal-count flag and one-cycle overflow/error pulses.
module mod_n_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 14
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic             enable,
    input  logic             mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ovf,
    output logic             err
);

    // One extra bit so MODULUS == 2**WIDTH and up-sums never truncate.
    localparam int unsigned EW          = WIDTH + 1;
    localparam logic [EW-1:0]    MOD_E  = EW'(MODULUS);
    localparam logic [WIDTH-1:0] TOP    = WIDTH'(MODULUS - 1);

    logic [EW-1:0]    cnt_e;
    logic [EW-1:0]    step_e;
    logic [EW-1:0]    din_e;
    logic [EW-1:0]    sum_e;
    logic [EW-1:0]    wrap_up_e;
    logic [EW-1:0]    wrap_dn_e;
    logic [WIDTH-1:0] cnt_d;
    logic             ovf_d;
    logic             err_d;

    assign cnt_e     = {1'b0, data_out};
    assign step_e    = {1'b0, step};
    assign din_e     = {1'b0, data_in};
    assign sum_e     = cnt_e + step_e;
    assign wrap_up_e = sum_e - MOD_E;
    assign wrap_dn_e = cnt_e + MOD_E - step_e;

    // Next count and pulse flags; priority load > enable > hold.
    always_comb begin
        cnt_d = data_out;
        ovf_d = 1'b0;
        err_d = 1'b0;
        if (load) begin
            if (din_e < MOD_E) begin
                cnt_d = data_in;
            end else begin
                err_d = 1'b1;
            end
        end else if (enable) begin
            if (step_e >= MOD_E) begin
                err_d = 1'b1;
            end else if (step != '0) begin
                if (mode) begin
                    if (sum_e < MOD_E) begin
                        cnt_d = WIDTH'(sum_e);
                    end else if (sat) begin
                        cnt_d = TOP;
                        ovf_d = (data_out != TOP);
                    end else begin
                        cnt_d = WIDTH'(wrap_up_e);
                        ovf_d = 1'b1;
                    end
                end else begin
                    if (step <= data_out) begin
                        cnt_d = data_out - step;
                    end else if (sat) begin
                        cnt_d = '0;
                        ovf_d = (data_out != '0);
                    end else begin
                        cnt_d = WIDTH'(wrap_dn_e);
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            data_out <= cnt_d;
            ovf      <= ovf_d;
            err      <= err_d;
        end
    end

    // Terminal count follows mode combinationally.
    assign tc = mode ? (data_out == TOP) : (data_out == '0);

endmodule
